bin2rgb: RTL and testbench

BIN2RGB -- requirements
Module: bin2rgb

---
 rtl/bin2rgb_if.sv | 45 ++++
 rtl/bin2rgb.sv | 157 +++++++++++++++
 tb/tb_bin2rgb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bin2rgb_if.sv
// Pixel-stream bundle for bin2rgb: binarized class bits, original pixel,
// display controls going in; rendered pixel and per-frame class counts out.
interface bin2rgb_if #(
  parameter int COUNT_WIDTH = 20
);
  logic                   in_red_threshold;
  logic                   in_green_threshold;
  logic                   in_blue_threshold;
  logic                   in_gray_threshold;
  logic                   in_valid;
  logic                   in_frame_start;
  logic [9:0]             in_red;
  logic [9:0]             in_green;
  logic [9:0]             in_blue;
  logic [1:0]             in_mode;
  logic [31:0]            in_red_color;
  logic [31:0]            in_green_color;
  logic [31:0]            in_blue_color;
  logic [9:0]             out_red;
  logic [9:0]             out_green;
  logic [9:0]             out_blue;
  logic                   out_valid;
  logic [COUNT_WIDTH-1:0] out_red_count;
  logic [COUNT_WIDTH-1:0] out_green_count;
  logic [COUNT_WIDTH-1:0] out_blue_count;
  logic                   out_count_valid;

  // Source of the pixel stream / sink of results
  modport master (
    output in_red_threshold, in_green_threshold, in_blue_threshold, in_gray_threshold,
    output in_valid, in_frame_start, in_red, in_green, in_blue, in_mode,
    output in_red_color, in_green_color, in_blue_color,
    input  out_red, out_green, out_blue, out_valid,
    input  out_red_count, out_green_count, out_blue_count, out_count_valid
  );

  // The renderer itself
  modport slave (
    input  in_red_threshold, in_green_threshold, in_blue_threshold, in_gray_threshold,
    input  in_valid, in_frame_start, in_red, in_green, in_blue, in_mode,
    input  in_red_color, in_green_color, in_blue_color,
    output out_red, out_green, out_blue, out_valid,
    output out_red_count, out_green_count, out_blue_count, out_count_valid
  );
endinterface

// File: rtl/bin2rgb.sv
// bin2rgb: renders binarized class bits into a display pixel (1-cycle
// latency) and counts set pixels per class, reporting counts per frame.

// Saturating per-class pixel counter; restart reloads with this cycle's hit.
module bin2rgb_cls_cnt #(
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         restart_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q, count_d;

  // Next count: restart wins, otherwise increment until saturated
  always_comb begin
    count_d = count_q;
    if (restart_i)
      count_d = {{(W-1){1'b0}}, inc_i};
    else if (inc_i && (count_q != CNT_MAX))
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
endmodule

module bin2rgb #(
  parameter int COUNT_WIDTH = 20
) (
  input logic  clock,
  input logic  reset,
  bin2rgb_if.slave bus
);
  localparam int NUM_CLS = 3;  // 0 red, 1 green, 2 blue

  typedef enum logic {
    ST_NO_FRAME,   // no frame boundary seen since reset
    ST_IN_FRAME    // inside a frame; next boundary completes it
  } state_e;

  state_e                               state_q, state_d;
  logic [1:0]                           mode_q, mode_d;
  logic                                 rpt_pulse;

  logic [NUM_CLS-1:0]                   cls_inc;
  logic [NUM_CLS-1:0][COUNT_WIDTH-1:0]  cnt;
  logic [NUM_CLS-1:0][COUNT_WIDTH-1:0]  rpt_q, rpt_d;
  logic                                 rpt_vld_q;

  logic [29:0]                          col_sel;
  logic                                 any_cls;
  logic [29:0]                          pix_d, pix_q;
  logic                                 vld_q;

  // Frame tracking: a boundary only reports once a frame has been opened,
  // and the mode switch applies to the boundary cycle's own pixel.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rpt_pulse = 1'b0;
    if (bus.in_frame_start) begin
      state_d   = ST_IN_FRAME;
      mode_d    = bus.in_mode;
      rpt_pulse = (state_q == ST_IN_FRAME);
    end
  end

  // Frame state and active display mode
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_NO_FRAME;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign cls_inc = {bus.in_blue_threshold, bus.in_green_threshold, bus.in_red_threshold}
                   & {NUM_CLS{bus.in_valid}};

  for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
    bin2rgb_cls_cnt #(.W(COUNT_WIDTH)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .restart_i (bus.in_frame_start),
      .inc_i     (cls_inc[c]),
      .count_o   (cnt[c])
    );
  end

  // Snapshot the running counts at each completed frame boundary
  always_comb begin
    rpt_d = rpt_q;
    if (rpt_pulse) rpt_d = cnt;
  end

  // Reported counts and their one-cycle update strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_q     <= '0;
      rpt_vld_q <= 1'b0;
    end else begin
      rpt_q     <= rpt_d;
      rpt_vld_q <= rpt_pulse;
    end
  end

  // Pixel rendering for the mode in effect this cycle (red > green > blue)
  always_comb begin
    any_cls = bus.in_red_threshold | bus.in_green_threshold | bus.in_blue_threshold;
    if (bus.in_red_threshold)        col_sel = bus.in_red_color[29:0];
    else if (bus.in_green_threshold) col_sel = bus.in_green_color[29:0];
    else                             col_sel = bus.in_blue_color[29:0];
    pix_d = {bus.in_red, bus.in_green, bus.in_blue};
    case (mode_d)
      2'd0: pix_d = {bus.in_red, bus.in_green, bus.in_blue};
      2'd1: pix_d = any_cls ? col_sel : 30'd0;
      2'd2: pix_d = any_cls ? col_sel : {bus.in_red, bus.in_green, bus.in_blue};
      default: pix_d = bus.in_gray_threshold ? {3{10'h3FF}} : 30'd0;
    endcase
  end

  // Output pixel register; zeroed whenever the slot is not valid
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pix_q <= bus.in_valid ? pix_d : 30'd0;
      vld_q <= bus.in_valid;
    end
  end

  assign bus.out_red         = pix_q[29:20];
  assign bus.out_green       = pix_q[19:10];
  assign bus.out_blue        = pix_q[9:0];
  assign bus.out_valid       = vld_q;
  assign bus.out_red_count   = rpt_q[0];
  assign bus.out_green_count = rpt_q[1];
  assign bus.out_blue_count  = rpt_q[2];
  assign bus.out_count_valid = rpt_vld_q;

  // Colour words carry two spare top bits
  logic unused_col;
  assign unused_col = ^{bus.in_red_color[31:30], bus.in_green_color[31:30],
                        bus.in_blue_color[31:30]};
endmodule

// File: tb/tb_bin2rgb.sv
// Scoreboard bench for bin2rgb: a behavioural model pushes the expected
// next-cycle outputs as stimulus is driven; they are popped and compared
// one cycle later. A second instance with 4-bit counters checks saturation.
module tb_bin2rgb;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bin2rgb_if #(.COUNT_WIDTH(20)) bus ();
  bin2rgb_if #(.COUNT_WIDTH(4))  bus4 ();

  bin2rgb #(.COUNT_WIDTH(20)) dut  (.clock(clock), .reset(reset), .bus(bus));
  bin2rgb #(.COUNT_WIDTH(4))  dut4 (.clock(clock), .reset(reset), .bus(bus4));

  // shared stimulus
  logic        s_tr, s_tg, s_tb, s_gy, s_v, s_fs;
  logic [1:0]  s_md;
  logic [9:0]  s_r, s_g, s_b;
  logic [31:0] s_rc, s_gc, s_bc;

  assign bus.in_red_threshold   = s_tr;  assign bus4.in_red_threshold   = s_tr;
  assign bus.in_green_threshold = s_tg;  assign bus4.in_green_threshold = s_tg;
  assign bus.in_blue_threshold  = s_tb;  assign bus4.in_blue_threshold  = s_tb;
  assign bus.in_gray_threshold  = s_gy;  assign bus4.in_gray_threshold  = s_gy;
  assign bus.in_valid           = s_v;   assign bus4.in_valid           = s_v;
  assign bus.in_frame_start     = s_fs;  assign bus4.in_frame_start     = s_fs;
  assign bus.in_mode            = s_md;  assign bus4.in_mode            = s_md;
  assign bus.in_red             = s_r;   assign bus4.in_red             = s_r;
  assign bus.in_green           = s_g;   assign bus4.in_green           = s_g;
  assign bus.in_blue            = s_b;   assign bus4.in_blue            = s_b;
  assign bus.in_red_color       = s_rc;  assign bus4.in_red_color       = s_rc;
  assign bus.in_green_color     = s_gc;  assign bus4.in_green_color     = s_gc;
  assign bus.in_blue_color      = s_bc;  assign bus4.in_blue_color      = s_bc;

  typedef struct {
    int unsigned vld, r, g, b, cv;
    int unsigned c[3];
    int unsigned c4[3];
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // model state
  int unsigned mode_m, seen_m;
  int unsigned cnt_m[3], cnt4_m[3], rep_m[3], rep4_m[3];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive, model, push; clock; pop and compare
  task automatic step(input bit rs, input bit fs, input bit v,
                      input bit tr, input bit tg, input bit tb, input bit gy,
                      input int unsigned md, input int unsigned pr,
                      input int unsigned pg, input int unsigned pb);
    exp_t e;
    bit   hit[3];
    reset = rs; s_fs = fs; s_v = v; s_tr = tr; s_tg = tg; s_tb = tb; s_gy = gy;
    s_md = md[1:0]; s_r = pr[9:0]; s_g = pg[9:0]; s_b = pb[9:0];
    e.vld = 0; e.r = 0; e.g = 0; e.b = 0; e.cv = 0;
    if (rs) begin
      mode_m = 0; seen_m = 0;
      for (int i = 0; i < 3; i++) begin
        cnt_m[i] = 0; cnt4_m[i] = 0; rep_m[i] = 0; rep4_m[i] = 0;
      end
    end else begin
      if (fs) mode_m = md;
      if (v) begin
        e.vld = 1;
        if (mode_m == 0 || (mode_m == 2 && !(tr || tg || tb))) begin
          e.r = pr; e.g = pg; e.b = pb;
        end else if (mode_m == 3) begin
          if (gy) begin e.r = 1023; e.g = 1023; e.b = 1023; end
        end else if (tr) begin
          e.r = (s_rc >> 20) & 1023; e.g = (s_rc >> 10) & 1023; e.b = s_rc & 1023;
        end else if (tg) begin
          e.r = (s_gc >> 20) & 1023; e.g = (s_gc >> 10) & 1023; e.b = s_gc & 1023;
        end else if (tb) begin
          e.r = (s_bc >> 20) & 1023; e.g = (s_bc >> 10) & 1023; e.b = s_bc & 1023;
        end
      end
      hit[0] = v && tr; hit[1] = v && tg; hit[2] = v && tb;
      if (fs) begin
        if (seen_m != 0) begin
          e.cv = 1;
          for (int i = 0; i < 3; i++) begin rep_m[i] = cnt_m[i]; rep4_m[i] = cnt4_m[i]; end
        end
        seen_m = 1;
        for (int i = 0; i < 3; i++) begin cnt_m[i] = hit[i]; cnt4_m[i] = hit[i]; end
      end else begin
        for (int i = 0; i < 3; i++) if (hit[i]) begin
          if (cnt_m[i] < 20'hFFFFF) cnt_m[i]++;
          if (cnt4_m[i] < 15) cnt4_m[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin e.c[i] = rep_m[i]; e.c4[i] = rep4_m[i]; end
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("out_valid", bus.out_valid, e.vld);
      chk("out_red", bus.out_red, e.r);
      chk("out_green", bus.out_green, e.g);
      chk("out_blue", bus.out_blue, e.b);
      chk("count_valid", bus.out_count_valid, e.cv);
      chk("red_count", bus.out_red_count, e.c[0]);
      chk("green_count", bus.out_green_count, e.c[1]);
      chk("blue_count", bus.out_blue_count, e.c[2]);
      chk("count_valid_w4", bus4.out_count_valid, e.cv);
      chk("red_count_w4", bus4.out_red_count, e.c4[0]);
      chk("green_count_w4", bus4.out_green_count, e.c4[1]);
      chk("blue_count_w4", bus4.out_blue_count, e.c4[2]);
    end
  endtask

  initial begin
    logic [9:0] rmask, gmask, bmask;
    s_rc = {2'b0, 10'd100, 10'd200, 10'd300};
    s_gc = {2'b0, 10'd7, 10'd8, 10'd9};
    s_bc = {2'b0, 10'd1000, 10'd500, 10'd3};

    // reset with garbage inputs: everything must read zero
    step(1, 1, 1, 1, 1, 1, 1, 2, 11, 22, 33);
    step(1, 0, 1, 1, 0, 0, 1, 0, 44, 55, 66);
    // first frame start, mode 1, red+green pixel -> red colour, no count pulse
    step(0, 1, 1, 1, 1, 0, 0, 1, 5, 6, 7);
    step(0, 0, 1, 0, 1, 1, 0, 1, 5, 6, 7);   // green colour
    step(0, 0, 1, 0, 0, 1, 0, 1, 5, 6, 7);   // blue colour
    step(0, 0, 1, 0, 0, 0, 1, 1, 5, 6, 7);   // no class -> black
    step(0, 0, 0, 1, 0, 0, 0, 1, 5, 6, 7);   // idle slot -> zero
    // mode 2 overlay; mid-frame mode request ignored
    step(0, 1, 1, 0, 0, 0, 0, 2, 512, 256, 128);
    step(0, 0, 1, 0, 0, 0, 1, 3, 512, 256, 128);
    step(0, 0, 1, 0, 1, 0, 1, 3, 512, 256, 128);
    step(0, 0, 1, 0, 0, 0, 1, 0, 9, 10, 11);
    // 10-pixel frame: 4 red, 3 green, 7 blue
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rmask = 10'b1111000000; gmask = 10'b0000111000; bmask = 10'b0111111100;
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, rmask[i], gmask[i], bmask[i], 0, 1, i, 2 * i, 3 * i);
    // boundary; pixel on it counts toward the new frame
    step(0, 1, 1, 1, 0, 0, 0, 0, 1, 2, 3);
    // 19 more red pixels: 20 total, w4 instance saturates at 15
    for (int i = 0; i < 19; i++)
      step(0, 0, 1, 1, 0, 0, 0, 0, i, i, i);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // back-to-back: empty frame
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // partial frame discarded by reset
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // first after reset: no pulse
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0);   // reports red=2
    // mode 3 gray mask with valid gaps
    for (int i = 0; i < 8; i++)
      step(0, 0, (i % 2) == 0, 0, 0, 0, 1, 3, 77, 88, 99);
    // random traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) s_rc = $urandom;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
